// File: rtl/bool_check_sequencer.sv
// Check sequencer: fetches boolean check descriptors, issues each to a shared evaluator,
// compares the returned result against the expected value and reports an aggregate verdict.
module bool_check_sequencer #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_checks,
    input  logic             chk_valid,
    output logic             chk_ready,
    input  logic [1:0]       chk_op,
    input  logic             chk_a,
    input  logic             chk_b,
    input  logic             chk_exp,
    output logic             ev_req,
    output logic [1:0]       ev_op,
    output logic             ev_a,
    output logic             ev_b,
    input  logic             ev_ack,
    input  logic             ev_result,
    output logic             busy,
    output logic             done,
    output logic             passed,
    output logic             timeout,
    output logic [CNT_W-1:0] fail_idx,
    output logic [CNT_W-1:0] checks_run
);

    localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] NONE = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StCheck,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             to_q, to_d;
    logic [1:0]       op_q, op_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             exp_q, exp_d;
    logic             res_q, res_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             mismatch;

    assign mismatch = res_q ^ exp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            run_q   <= '0;
            fail_q  <= NONE;
            to_q    <= 1'b0;
            op_q    <= 2'b00;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            exp_q   <= 1'b0;
            res_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            run_q   <= run_d;
            fail_q  <= fail_d;
            to_q    <= to_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        run_d   = run_q;
        fail_d  = fail_q;
        to_d    = to_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        exp_d   = exp_q;
        res_d   = res_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d   = num_checks;
                    run_d   = '0;
                    to_d    = 1'b0;
                    fail_d  = NONE;
                    state_d = (num_checks == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (chk_valid) begin
                    op_d    = chk_op;
                    a_d     = chk_a;
                    b_d     = chk_b;
                    exp_d   = chk_exp;
                    tcnt_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (ev_ack) begin
                    res_d   = ev_result;
                    state_d = StCheck;
                end else if (tcnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    if (fail_q == NONE) fail_d = run_q;
                    state_d = StDone;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (mismatch && (fail_q == NONE)) fail_d = run_q;
                run_d = run_q + 1'b1;
                if (((run_q + 1'b1) == num_q) || (mismatch && STOP_ON_FAIL)) begin
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign chk_ready  = (state_q == StFetch);
    assign ev_req     = (state_q == StIssue);
    assign busy       = (state_q == StFetch) || (state_q == StIssue) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign passed     = done && (fail_q == NONE) && !to_q;
    assign timeout    = to_q;
    assign fail_idx   = fail_q;
    assign checks_run = run_q;
    assign ev_op      = op_q;
    assign ev_a       = a_q;
    assign ev_b       = b_q;

endmodule

// File: tb/tb_bool_check_sequencer.sv
// Bench for bool_check_sequencer: two instances (run-all and stop-on-fail), each with its own
// descriptor source and evaluator model; table vectors, a reset corner case and random runs.
module tb_bool_check_sequencer;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_s     [2];
    logic [7:0] num_s       [2];
    logic       chk_valid_s [2];
    logic       chk_ready_s [2];
    logic [1:0] chk_op_s    [2];
    logic       chk_a_s     [2];
    logic       chk_b_s     [2];
    logic       chk_exp_s   [2];
    logic       ev_req_s    [2];
    logic [1:0] ev_op_s     [2];
    logic       ev_a_s      [2];
    logic       ev_b_s      [2];
    logic       ev_ack_s    [2];
    logic       ev_result_s [2];
    logic       busy_s      [2];
    logic       done_s      [2];
    logic       passed_s    [2];
    logic       timeout_s   [2];
    logic [7:0] fail_s      [2];
    logic [7:0] run_s       [2];

    // Per-instance run configuration, written only by the main process.
    logic [15:0] d_ops [2];
    logic [7:0]  d_a   [2];
    logic [7:0]  d_b   [2];
    logic [7:0]  d_e   [2];
    int          d_n   [2];
    int          d_gap [2];
    int          d_dly [2];
    int          d_nev [2];
    int          run_id   [2];
    int          stab_err [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bool_check_sequencer #(.CNT_W(8), .ACK_TIMEOUT(T), .STOP_ON_FAIL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .num_checks(num_s[0]),
        .chk_valid(chk_valid_s[0]), .chk_ready(chk_ready_s[0]), .chk_op(chk_op_s[0]),
        .chk_a(chk_a_s[0]), .chk_b(chk_b_s[0]), .chk_exp(chk_exp_s[0]),
        .ev_req(ev_req_s[0]), .ev_op(ev_op_s[0]), .ev_a(ev_a_s[0]), .ev_b(ev_b_s[0]),
        .ev_ack(ev_ack_s[0]), .ev_result(ev_result_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .passed(passed_s[0]), .timeout(timeout_s[0]),
        .fail_idx(fail_s[0]), .checks_run(run_s[0])
    );

    bool_check_sequencer #(.CNT_W(8), .ACK_TIMEOUT(T), .STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .num_checks(num_s[1]),
        .chk_valid(chk_valid_s[1]), .chk_ready(chk_ready_s[1]), .chk_op(chk_op_s[1]),
        .chk_a(chk_a_s[1]), .chk_b(chk_b_s[1]), .chk_exp(chk_exp_s[1]),
        .ev_req(ev_req_s[1]), .ev_op(ev_op_s[1]), .ev_a(ev_a_s[1]), .ev_b(ev_b_s[1]),
        .ev_ack(ev_ack_s[1]), .ev_result(ev_result_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .passed(passed_s[1]), .timeout(timeout_s[1]),
        .fail_idx(fail_s[1]), .checks_run(run_s[1])
    );

    function automatic logic evalf(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~a;
            default: return a;
        endcase
    endfunction

    // Descriptor source and evaluator, both acting on the falling edge.
    for (genvar k = 0; k < 2; k++) begin : g_env
        initial begin
            int ptr, gcnt, wt, issue, last;
            bit fire, vld;
            logic [1:0] cop;
            logic ca, cb;
            ptr = 0; gcnt = 0; wt = 0; issue = 0; last = 0; fire = 0;
            cop = 2'b00; ca = 1'b0; cb = 1'b0;
            chk_valid_s[k] = 1'b0; chk_op_s[k] = 2'b00; chk_a_s[k] = 1'b0;
            chk_b_s[k] = 1'b0; chk_exp_s[k] = 1'b0; ev_ack_s[k] = 1'b0; ev_result_s[k] = 1'b0;
            forever begin
                @(negedge clk);
                if (run_id[k] != last) begin
                    last = run_id[k]; ptr = 0; gcnt = 0; fire = 0; issue = 0; wt = 0;
                end else if (fire) begin
                    ptr++; gcnt = 0;
                end
                vld = (ptr < d_n[k]) && (gcnt >= d_gap[k]);
                chk_valid_s[k] = vld;
                if (vld) begin
                    chk_op_s[k]  = d_ops[k][2*ptr +: 2];
                    chk_a_s[k]   = d_a[k][ptr];
                    chk_b_s[k]   = d_b[k][ptr];
                    chk_exp_s[k] = d_e[k][ptr];
                end else begin
                    chk_op_s[k] = 2'($urandom);
                    chk_a_s[k]  = 1'($urandom);
                    if (chk_ready_s[k]) gcnt++;
                end
                fire = vld && chk_ready_s[k];
                if (ev_req_s[k]) begin
                    if (wt == 0) begin
                        issue++;
                        cop = ev_op_s[k]; ca = ev_a_s[k]; cb = ev_b_s[k];
                    end else if ({ev_op_s[k], ev_a_s[k], ev_b_s[k]} != {cop, ca, cb}) begin
                        stab_err[k]++;
                    end
                    if ((issue - 1 != d_nev[k]) && (wt >= d_dly[k])) begin
                        ev_ack_s[k]    = 1'b1;
                        ev_result_s[k] = evalf(ev_op_s[k], ev_a_s[k], ev_b_s[k]);
                    end else begin
                        ev_ack_s[k]    = 1'b0;
                        ev_result_s[k] = 1'($urandom);
                    end
                    wt++;
                end else begin
                    wt = 0;
                    ev_ack_s[k]    = 1'($urandom);
                    ev_result_s[k] = 1'($urandom);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Spec-level model of a run's verdict.
    task automatic model(input int n, input logic [15:0] ops, input logic [7:0] av, bv, ev,
                         input int nev, input bit stop, output bit p, output int f,
                         output int run, output bit to);
        f = 255; run = 0; to = 0;
        for (int i = 0; i < n; i++) begin
            if (i == nev) begin
                to = 1;
                if (f == 255) f = i;
                break;
            end
            run = i + 1;
            if (evalf(ops[2*i +: 2], av[i], bv[i]) != ev[i]) begin
                if (f == 255) f = i;
                if (stop) break;
            end
        end
        p = (f == 255) && !to;
    endtask

    task automatic configure(input int k, input int n, input logic [15:0] ops,
                             input logic [7:0] av, bv, ev, input int gap, dly, nev);
        d_ops[k] = ops; d_a[k] = av; d_b[k] = bv; d_e[k] = ev;
        d_n[k] = n; d_gap[k] = gap; d_dly[k] = dly; d_nev[k] = nev;
        run_id[k]++;
        @(negedge clk);
    endtask

    task automatic do_run(input int k, input int n, input bit mid, output int cyc,
                          output bit ready_seen);
        start_s[k] = 1'b1;
        num_s[k] = 8'(n);
        cyc = 0;
        ready_seen = 0;
        forever begin
            @(negedge clk);
            start_s[k] = 1'b0;
            cyc++;
            if (chk_ready_s[k]) ready_seen = 1;
            if (done_s[k]) break;
            if (mid && cyc == 6) begin
                start_s[k] = 1'b1;
                num_s[k] = 8'd3;
            end
            if (cyc > 2000) begin
                check("run_bound", 0, 1);
                break;
            end
        end
    endtask

    task automatic check_end(input int k, input bit p, input int f, input int run, input bit to,
                             input int exp_cyc, input int cyc);
        check("done", done_s[k], 1);
        check("passed", passed_s[k], p);
        check("fail_idx", fail_s[k], f);
        check("checks_run", run_s[k], run);
        check("timeout", timeout_s[k], to);
        check("busy_end", busy_s[k], 0);
        check("ev_req_end", ev_req_s[k], 0);
        check("ready_end", chk_ready_s[k], 0);
        check("latency", cyc, exp_cyc);
        check("stable", stab_err[k], 0);
    endtask

    typedef struct {
        int          k;
        int          n;
        logic [15:0] ops;
        logic [7:0]  av, bv, ev;
        int          gap, dly, nev;
        bit          mid;
        bit          p;
        int          f, run;
        bit          to;
        int          cyc;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int  cyc, f, run;
        bit  rs, p, to;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; num_s[k] = 8'd0; run_id[k] = 0; stab_err[k] = 0;
            d_n[k] = 0; d_gap[k] = 0; d_dly[k] = 0; d_nev[k] = -1;
            d_ops[k] = '0; d_a[k] = '0; d_b[k] = '0; d_e[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_done", done_s[k], 0);
            check("rst_busy", busy_s[k], 0);
            check("rst_ready", chk_ready_s[k], 0);
            check("rst_req", ev_req_s[k], 0);
            check("rst_fail", fail_s[k], 255);
            check("rst_run", run_s[k], 0);
            check("rst_passed", passed_s[k], 0);
            check("rst_timeout", timeout_s[k], 0);
        end
        rst_n = 1'b1;

        // AND(1,1)=1, AND(1,0)=0, OR(0,0)=0, NOT(0)=1; 4'hD sets a wrong expectation on check 2.
        tbl[0] = '{k:0, n:4, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h09, gap:0, dly:0, nev:-1,
                   mid:0, p:1, f:255, run:4, to:0, cyc:13};
        tbl[1] = '{k:0, n:4, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h0D, gap:0, dly:0, nev:-1,
                   mid:0, p:0, f:2, run:4, to:0, cyc:13};
        tbl[2] = '{k:1, n:4, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h0D, gap:0, dly:0, nev:-1,
                   mid:0, p:0, f:2, run:3, to:0, cyc:10};
        tbl[3] = '{k:0, n:4, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h09, gap:0, dly:0, nev:1,
                   mid:0, p:0, f:1, run:1, to:1, cyc:21};
        tbl[4] = '{k:0, n:4, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h09, gap:3, dly:5, nev:-1,
                   mid:1, p:1, f:255, run:4, to:0, cyc:45};
        tbl[5] = '{k:0, n:0, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h09, gap:0, dly:0, nev:-1,
                   mid:0, p:1, f:255, run:0, to:0, cyc:1};
        tbl[6] = '{k:1, n:4, ops:16'h0090, av:8'h03, bv:8'h01, ev:8'h09, gap:0, dly:0, nev:-1,
                   mid:0, p:1, f:255, run:4, to:0, cyc:13};

        for (int i = 0; i < 7; i++) begin
            configure(tbl[i].k, tbl[i].n, tbl[i].ops, tbl[i].av, tbl[i].bv, tbl[i].ev,
                      tbl[i].gap, tbl[i].dly, tbl[i].nev);
            do_run(tbl[i].k, tbl[i].n, tbl[i].mid, cyc, rs);
            check_end(tbl[i].k, tbl[i].p, tbl[i].f, tbl[i].run, tbl[i].to, tbl[i].cyc, cyc);
            if (tbl[i].n == 0) check("ready_never", rs, 0);
            repeat (2) @(negedge clk);
            check("done_hold", done_s[tbl[i].k], 1);
        end

        // Reset while check 1 (OR(1,1)) is in ISSUE with a slow evaluator.
        configure(0, 3, 16'h0004, 8'h03, 8'h03, 8'h03, 0, 5, -1);
        begin
            int rises;
            bit prev;
            rises = 0; prev = 0;
            start_s[0] = 1'b1; num_s[0] = 8'd3;
            for (int c = 0; c < 200 && rises < 2; c++) begin
                @(negedge clk);
                start_s[0] = 1'b0;
                if (ev_req_s[0] && !prev) rises++;
                prev = ev_req_s[0];
            end
            check("pre_rst_req", ev_req_s[0], 1);
            check("pre_rst_op", ev_op_s[0], 1);
            rst_n = 1'b0;
            @(negedge clk);
            check("mid_rst_req", ev_req_s[0], 0);
            check("mid_rst_busy", busy_s[0], 0);
            check("mid_rst_done", done_s[0], 0);
            check("mid_rst_op", {ev_op_s[0], ev_a_s[0], ev_b_s[0]}, 0);
            check("mid_rst_run", run_s[0], 0);
            check("mid_rst_fail", fail_s[0], 255);
            rst_n = 1'b1;
        end
        configure(0, 2, 16'h0090, 8'h03, 8'h01, 8'h09, 0, 0, -1);
        do_run(0, 2, 0, cyc, rs);
        check_end(0, 1, 255, 2, 0, 7, cyc);

        // Random runs against the model.
        for (int it = 0; it < 40; it++) begin
            int k, n, gap, dly, nev;
            logic [15:0] ops;
            logic [7:0] av, bv, ev;
            bit mid;
            k = it % 2;
            n = int'($urandom_range(1, 8));
            gap = int'($urandom_range(0, 3));
            dly = int'($urandom_range(0, 6));
            nev = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            mid = ($urandom_range(0, 3) == 0);
            ops = 16'($urandom); av = 8'($urandom); bv = 8'($urandom); ev = '0;
            for (int i = 0; i < 8; i++) begin
                ev[i] = evalf(ops[2*i +: 2], av[i], bv[i]) ^ ($urandom_range(0, 3) == 0);
            end
            model(n, ops, av, bv, ev, nev, (k == 1), p, f, run, to);
            configure(k, n, ops, av, bv, ev, gap, dly, nev);
            do_run(k, n, mid, cyc, rs);
            check_end(k, p, f, run, to, 1 + (3 + dly + gap) * run + (to ? (1 + gap + T) : 0),
                      cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
